// File: rtl/cei_mochila_pkg.sv
// System-level constants for the triple-core platform.
// The scratchpad base address and size, and the read data returned for
// accesses that fall outside the scratchpad window.
package cei_mochila_pkg;

    localparam logic [31:0] ScratchBaseAddr = 32'h0000_0000;
    localparam int unsigned ScratchNumWords = 32'd1024;
    localparam logic [31:0] ScratchErrRdata = 32'hBADC_AB1E;

endpackage

// File: rtl/obi_pkg.sv
// OBI bus types shared by every initiator and target in the system.
//   obi_req_t  : req, we, be[3:0], addr[31:0], wdata[31:0]  (initiator -> target)
//   obi_resp_t : gnt, rvalid, rdata[31:0]                    (target -> initiator)
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/obi_mem_responder_chk.sv
// Elaboration-time parameter checks for obi_mem_responder.
// No ports; instantiated inside the responder so that an illegal
// parameter set stops elaboration.
module obi_mem_responder_chk #(
    parameter int unsigned NumWords       = 32'd1024,
    parameter int unsigned RespLatency    = 32'd1,
    parameter int unsigned MaxOutstanding = 32'd2
) ();

    if (RespLatency < 32'd1) begin : g_bad_latency
        $error("obi_mem_responder: RespLatency must be at least 1");
    end

    if (MaxOutstanding < 32'd1) begin : g_bad_max_out
        $error("obi_mem_responder: MaxOutstanding must be at least 1");
    end

    if (MaxOutstanding > RespLatency + 32'd1) begin : g_big_max_out
        $error("obi_mem_responder: MaxOutstanding must not exceed RespLatency+1");
    end

    if ((NumWords < 32'd2) || ((NumWords & (NumWords - 32'd1)) != 32'd0)) begin : g_bad_words
        $error("obi_mem_responder: NumWords must be a power of two >= 2");
    end

endmodule

// File: rtl/obi_resp_pipe.sv
// Fixed-latency response pipeline for the OBI responder.
// A response entered on in_valid_i appears on out_valid_o exactly Latency
// cycles later. out_data_o holds the last delivered data while idle.
// inflight_o counts accepted-but-unanswered transactions (+1 on in, -1 on out).
//   clk_i, rst_ni : clock, async active-low reset
//   in_valid_i    : transaction accepted this cycle
//   in_data_i     : response data for that transaction
//   out_valid_o   : rvalid
//   out_data_o    : rdata
//   inflight_o    : outstanding transaction count
module obi_resp_pipe #(
    parameter int unsigned Latency        = 32'd1,
    parameter int unsigned MaxOutstanding = 32'd2,
    parameter int unsigned CntW           = $clog2(MaxOutstanding + 32'd1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    input  logic [31:0]     in_data_i,
    output logic            out_valid_o,
    output logic [31:0]     out_data_o,
    output logic [CntW-1:0] inflight_o
);

    logic [Latency-1:0] valid_r;
    logic [31:0]        data_r [Latency];
    logic [CntW-1:0]    cnt_r;

    // Shift valid bits every cycle; data only moves with a valid so that
    // the last stage keeps its value between responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r <= {Latency{1'b0}};
            for (int i = 0; i < int'(Latency); i++) begin
                data_r[i] <= 32'h0000_0000;
            end
        end else begin
            valid_r[0] <= in_valid_i;
            if (in_valid_i) begin
                data_r[0] <= in_data_i;
            end
            for (int i = 1; i < int'(Latency); i++) begin
                valid_r[i] <= valid_r[i-1];
                if (valid_r[i-1]) begin
                    data_r[i] <= data_r[i-1];
                end
            end
        end
    end

    // Outstanding count: accept and response in the same cycle cancel out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= {CntW{1'b0}};
        end else begin
            case ({in_valid_i, valid_r[Latency-1]})
                2'b10:   cnt_r <= cnt_r + CntW'(1);
                2'b01:   cnt_r <= cnt_r - CntW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign out_valid_o = valid_r[Latency-1];
    assign out_data_o  = data_r[Latency-1];
    assign inflight_o  = cnt_r;

endmodule

// File: rtl/obi_mem_responder.sv
// OBI target terminating one initiator port with a word-addressed scratch
// memory. Byte-enable writes, optional grant wait states, fixed response
// latency and a bound on granted-but-unanswered transactions.
//   clk_i, rst_ni : clock, async active-low reset (memory is not reset)
//   obi_req_i     : req, we, be, addr, wdata from the initiator
//   obi_resp_o    : gnt (combinational), rvalid/rdata (registered)
module obi_mem_responder
    import obi_pkg::*;
    import cei_mochila_pkg::*;
#(
    parameter int unsigned NumWords       = ScratchNumWords,
    parameter logic [31:0] BaseAddr       = ScratchBaseAddr,
    parameter int unsigned GntDelay       = 32'd0,
    parameter int unsigned RespLatency    = 32'd1,
    parameter int unsigned MaxOutstanding = 32'd2,
    parameter logic [31:0] ErrRdata       = ScratchErrRdata
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  obi_req_t  obi_req_i,
    output obi_resp_t obi_resp_o
);

    localparam int unsigned AddrW     = $clog2(NumWords);
    localparam int unsigned CntW      = $clog2(MaxOutstanding + 32'd1);
    localparam logic [32:0] SpanBytes = 33'(NumWords) << 2;
    localparam logic [CntW-1:0] MaxOut = CntW'(MaxOutstanding);

    obi_mem_responder_chk #(
        .NumWords       (NumWords),
        .RespLatency    (RespLatency),
        .MaxOutstanding (MaxOutstanding)
    ) u_chk ();

    logic [31:0]      mem_r [NumWords];
    logic [31:0]      offset_s;
    logic             in_range_s;
    logic [AddrW-1:0] idx_s;
    logic             room_s;
    logic             gnt_s;
    logic             accept_s;
    logic [31:0]      rsp_data_s;
    logic             pipe_valid_s;
    logic [31:0]      pipe_data_s;
    logic [CntW-1:0]  inflight_s;

    // Unsigned offset wraps below BaseAddr, so one compare covers both bounds.
    assign offset_s   = obi_req_i.addr - BaseAddr;
    assign in_range_s = ({1'b0, offset_s} < SpanBytes);
    assign idx_s      = offset_s[AddrW+1:2];

    // A response leaving this cycle frees its slot in time for a new grant.
    assign room_s   = (inflight_s < MaxOut) || pipe_valid_s;
    assign accept_s = obi_req_i.req && gnt_s;

    if (GntDelay == 32'd0) begin : g_no_wait
        assign gnt_s = obi_req_i.req && room_s;
    end else begin : g_wait
        typedef enum logic {
            GntIdle = 1'b0,
            GntWait = 1'b1
        } gnt_state_e;

        localparam int unsigned WcntW = $clog2(GntDelay + 32'd1);
        localparam logic [WcntW-1:0] WcntMax = WcntW'(GntDelay);

        gnt_state_e       state_r;
        logic [WcntW-1:0] wcnt_r;

        assign gnt_s = obi_req_i.req && (state_r == GntWait) &&
                       (wcnt_r == WcntMax) && room_s;

        // Grant wait-state FSM; every request pays the full delay, and a
        // request withdrawn while waiting is abandoned without an access.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_r <= GntIdle;
                wcnt_r  <= {WcntW{1'b0}};
            end else begin
                case (state_r)
                    GntIdle: begin
                        if (obi_req_i.req) begin
                            state_r <= GntWait;
                            wcnt_r  <= WcntW'(1);
                        end else begin
                            state_r <= GntIdle;
                            wcnt_r  <= {WcntW{1'b0}};
                        end
                    end
                    GntWait: begin
                        if (!obi_req_i.req || gnt_s) begin
                            state_r <= GntIdle;
                            wcnt_r  <= {WcntW{1'b0}};
                        end else if (wcnt_r != WcntMax) begin
                            wcnt_r  <= wcnt_r + WcntW'(1);
                        end else begin
                            // Delay served but no slot free: keep waiting.
                            wcnt_r  <= wcnt_r;
                        end
                    end
                    default: begin
                        state_r <= GntIdle;
                        wcnt_r  <= {WcntW{1'b0}};
                    end
                endcase
            end
        end
    end

    // Byte-enable write at the accept edge; out-of-range writes are dropped.
    always_ff @(posedge clk_i) begin
        if (accept_s && obi_req_i.we && in_range_s) begin
            for (int i = 0; i < 4; i++) begin
                if (obi_req_i.be[i]) begin
                    mem_r[idx_s][8*i +: 8] <= obi_req_i.wdata[8*i +: 8];
                end
            end
        end
    end

    // Response data captured at the accept edge: 0 for writes, array data
    // for in-range reads, the error pattern otherwise.
    always_comb begin
        rsp_data_s = 32'h0000_0000;
        if (obi_req_i.we) begin
            rsp_data_s = 32'h0000_0000;
        end else if (in_range_s) begin
            rsp_data_s = mem_r[idx_s];
        end else begin
            rsp_data_s = ErrRdata;
        end
    end

    obi_resp_pipe #(
        .Latency        (RespLatency),
        .MaxOutstanding (MaxOutstanding),
        .CntW           (CntW)
    ) u_resp_pipe (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (accept_s),
        .in_data_i   (rsp_data_s),
        .out_valid_o (pipe_valid_s),
        .out_data_o  (pipe_data_s),
        .inflight_o  (inflight_s)
    );

    assign obi_resp_o = '{gnt: gnt_s, rvalid: pipe_valid_s, rdata: pipe_data_s};

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench for obi_mem_responder. Four instances cover the default
// configuration, grant wait states, the outstanding limit and reset during
// an in-flight read. Inputs change 1 time unit after posedge; outputs are
// sampled on negedge.
module tb_obi_mem_responder;
    import obi_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      rst2_n;
    obi_req_t  req_def, req_gd, req_lat, req_rst;
    obi_resp_t rsp_def, rsp_gd, rsp_lat, rsp_rst;
    int        vectors = 0;
    int        miscompares = 0;

    always #5 clk = ~clk;

    obi_mem_responder u_def (
        .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req_def), .obi_resp_o(rsp_def));

    obi_mem_responder #(.GntDelay(32'd3)) u_gd (
        .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req_gd), .obi_resp_o(rsp_gd));

    obi_mem_responder #(.RespLatency(32'd3), .MaxOutstanding(32'd2)) u_lat (
        .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req_lat), .obi_resp_o(rsp_lat));

    obi_mem_responder #(.RespLatency(32'd2)) u_rst (
        .clk_i(clk), .rst_ni(rst2_n), .obi_req_i(req_rst), .obi_resp_o(rsp_rst));

    function automatic obi_req_t mk(input logic req, input logic we, input logic [3:0] be,
                                    input logic [31:0] addr, input logic [31:0] wdata);
        obi_req_t r;
        r.req = req; r.we = we; r.be = be; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction on u_def: request for one cycle, then idle.
    task automatic def_beat(input logic we, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic gnt, output logic rv,
                            output logic [31:0] rdata);
        next_cycle;
        req_def = mk(1'b1, we, be, addr, wdata);
        @(negedge clk);
        gnt = rsp_def.gnt;
        next_cycle;
        req_def = mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        rv = rsp_def.rvalid;
        rdata = rsp_def.rdata;
    endtask

    task automatic test_reset;
        req_gd = mk(1'b1, 1'b1, 4'hF, 32'h20, 32'h0);
        @(negedge clk);
        vectors++;
        if (rsp_def.rvalid !== 1'b0 || rsp_def.rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_def: rvalid=%b rdata=%h want 0/00000000", rsp_def.rvalid, rsp_def.rdata);
        end
        vectors++;
        if (rsp_gd.gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_gd_gnt: got %b want 0", rsp_gd.gnt);
        end
        vectors++;
        if (rsp_lat.rvalid !== 1'b0 || rsp_lat.rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_lat: rvalid=%b rdata=%h want 0/00000000", rsp_lat.rvalid, rsp_lat.rdata);
        end
        vectors++;
        if (rsp_rst.rvalid !== 1'b0 || rsp_rst.rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rst: rvalid=%b rdata=%h want 0/00000000", rsp_rst.rvalid, rsp_rst.rdata);
        end
        req_gd = mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        next_cycle;
        rst_n = 1'b1;
        rst2_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic        exp_rv [4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp_rd [4]   = '{32'h0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF};
        logic        exp_gnt [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 4; c++) begin
            next_cycle;
            case (c)
                0:       req_def = mk(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
                1:       req_def = mk(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
                default: req_def = mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            endcase
            @(negedge clk);
            vectors++;
            if (rsp_def.gnt !== exp_gnt[c]) begin
                miscompares++;
                $display("FAIL b2b_gnt[%0d]: got %b want %b", c, rsp_def.gnt, exp_gnt[c]);
            end
            vectors++;
            if (rsp_def.rvalid !== exp_rv[c]) begin
                miscompares++;
                $display("FAIL b2b_rvalid[%0d]: got %b want %b", c, rsp_def.rvalid, exp_rv[c]);
            end
            vectors++;
            if (rsp_def.rdata !== exp_rd[c]) begin
                miscompares++;
                $display("FAIL b2b_rdata[%0d]: got %h want %h", c, rsp_def.rdata, exp_rd[c]);
            end
        end
    endtask

    // Partial writes, ignored low address bits, out-of-range and last-word accesses.
    task automatic test_byte_enable_and_range;
        logic        we_t [10]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                                    1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0]  be_t [10]  = '{4'b0010, 4'hF, 4'hF, 4'b1001, 4'hF,
                                    4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        logic [31:0] ad_t [10]  = '{32'h10, 32'h10, 32'h13, 32'h12, 32'h10,
                                    32'h0, 32'h1000, 32'h1000, 32'h0, 32'hFFC};
        logic [31:0] wd_t [10]  = '{32'h0000_5500, 32'h0, 32'h0, 32'hAABB_CCDD, 32'h0,
                                    32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0F0F_0F0F};
        logic [31:0] ex_t [10]  = '{32'h0, 32'hDEAD55EF, 32'hDEAD55EF, 32'h0, 32'hAAAD55DD,
                                    32'h0, 32'hBADCAB1E, 32'h0, 32'h1234_5678, 32'h0};
        logic        g, rv;
        logic [31:0] rd;
        for (int i = 0; i < 10; i++) begin
            def_beat(we_t[i], be_t[i], ad_t[i], wd_t[i], g, rv, rd);
            vectors++;
            if (g !== 1'b1 || rv !== 1'b1) begin
                miscompares++;
                $display("FAIL beat_handshake[%0d]: gnt=%b rvalid=%b want 1/1", i, g, rv);
            end
            vectors++;
            if (rd !== ex_t[i]) begin
                miscompares++;
                $display("FAIL beat_rdata[%0d] addr %h: got %h want %h", i, ad_t[i], rd, ex_t[i]);
            end
        end
        def_beat(1'b0, 4'hF, 32'hFFC, 32'h0, g, rv, rd);
        vectors++;
        if (rd !== 32'h0F0F_0F0F) begin
            miscompares++;
            $display("FAIL last_word: got %h want 0f0f0f0f", rd);
        end
        def_beat(1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0, g, rv, rd);
        vectors++;
        if (rd !== 32'hBADCAB1E) begin
            miscompares++;
            $display("FAIL wrap_addr: got %h want badcab1e", rd);
        end
    endtask

    task automatic test_gnt_delay;
        logic [11:0] reqp = 12'b0111_1010_1111;
        logic [11:0] gntp = 12'b0100_0000_1000;
        logic [11:0] rvp  = 12'b1000_0001_0000;
        for (int c = 0; c < 12; c++) begin
            next_cycle;
            req_gd = mk(reqp[c], 1'b1, 4'hF, 32'h20, 32'(c));
            @(negedge clk);
            vectors++;
            if (rsp_gd.gnt !== gntp[c]) begin
                miscompares++;
                $display("FAIL gd_gnt[%0d]: got %b want %b", c, rsp_gd.gnt, gntp[c]);
            end
            vectors++;
            if (rsp_gd.rvalid !== rvp[c]) begin
                miscompares++;
                $display("FAIL gd_rvalid[%0d]: got %b want %b", c, rsp_gd.rvalid, rvp[c]);
            end
        end
        next_cycle;
        req_gd = mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_outstanding;
        logic [31:0] val_t [3]  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        logic [7:0]  reqp = 8'b0000_1111;
        logic [7:0]  gntp = 8'b0000_1011;
        logic [7:0]  rvp  = 8'b0101_1000;
        logic [31:0] ad_t [8] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] rd_t [8] = '{32'h0, 32'h0, 32'h0, 32'h1111_1111, 32'h2222_2222,
                                  32'h2222_2222, 32'h3333_3333, 32'h3333_3333};
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 4; c++) begin
                next_cycle;
                req_lat = mk(c == 0, 1'b1, 4'hF, 32'(4 * w), val_t[w]);
                @(negedge clk);
                vectors++;
                if (rsp_lat.gnt !== (c == 0) || rsp_lat.rvalid !== (c == 3)) begin
                    miscompares++;
                    $display("FAIL lat_setup[%0d.%0d]: gnt=%b rvalid=%b want %b/%b",
                             w, c, rsp_lat.gnt, rsp_lat.rvalid, c == 0, c == 3);
                end
            end
        end
        for (int c = 0; c < 8; c++) begin
            next_cycle;
            req_lat = mk(reqp[c], 1'b0, 4'hF, ad_t[c], 32'h0);
            @(negedge clk);
            vectors++;
            if (rsp_lat.gnt !== gntp[c]) begin
                miscompares++;
                $display("FAIL lat_gnt[%0d]: got %b want %b", c, rsp_lat.gnt, gntp[c]);
            end
            vectors++;
            if (rsp_lat.rvalid !== rvp[c]) begin
                miscompares++;
                $display("FAIL lat_rvalid[%0d]: got %b want %b", c, rsp_lat.rvalid, rvp[c]);
            end
            vectors++;
            if (rsp_lat.rdata !== rd_t[c]) begin
                miscompares++;
                $display("FAIL lat_rdata[%0d]: got %h want %h", c, rsp_lat.rdata, rd_t[c]);
            end
        end
    endtask

    task automatic test_reset_mid;
        // Setup write, then a read that is killed by reset, then a read that is not.
        for (int c = 0; c < 3; c++) begin
            next_cycle;
            req_rst = mk(c == 0, 1'b1, 4'hF, 32'h40, 32'hCAFE_F00D);
            @(negedge clk);
            vectors++;
            if (rsp_rst.gnt !== (c == 0) || rsp_rst.rvalid !== (c == 2)) begin
                miscompares++;
                $display("FAIL rst_setup[%0d]: gnt=%b rvalid=%b want %b/%b",
                         c, rsp_rst.gnt, rsp_rst.rvalid, c == 0, c == 2);
            end
        end
        next_cycle;
        req_rst = mk(1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        @(negedge clk);
        vectors++;
        if (rsp_rst.gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_read_gnt: got %b want 1", rsp_rst.gnt);
        end
        next_cycle;
        req_rst = mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst2_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (rsp_rst.rvalid !== 1'b0 || rsp_rst.rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_during: rvalid=%b rdata=%h want 0/00000000", rsp_rst.rvalid, rsp_rst.rdata);
        end
        for (int c = 0; c < 3; c++) begin
            next_cycle;
            rst2_n = 1'b1;
            @(negedge clk);
            vectors++;
            if (rsp_rst.rvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_discard[%0d]: rvalid got %b want 0", c, rsp_rst.rvalid);
            end
        end
        for (int c = 0; c < 3; c++) begin
            next_cycle;
            req_rst = mk(c == 0, 1'b0, 4'hF, 32'h40, 32'h0);
            @(negedge clk);
            vectors++;
            if (rsp_rst.gnt !== (c == 0) || rsp_rst.rvalid !== (c == 2)) begin
                miscompares++;
                $display("FAIL rst_reread[%0d]: gnt=%b rvalid=%b want %b/%b",
                         c, rsp_rst.gnt, rsp_rst.rvalid, c == 0, c == 2);
            end
        end
        vectors++;
        if (rsp_rst.rdata !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL rst_retained: got %h want cafef00d", rsp_rst.rdata);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rst2_n  = 1'b0;
        req_def = mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        req_gd  = mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        req_lat = mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        req_rst = mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        test_reset;
        test_back_to_back;
        test_byte_enable_and_range;
        test_gnt_delay;
        test_outstanding;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
